// File: rtl/io_tx_controller.sv
// Streams a stored image out of image SRAM in raster order as a valid/ready byte stream.
// Optional end-of-row flag output dout_eol is enabled by defining IO_TX_EOL_EN.
module io_tx_controller #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] nrows,
  input  logic [7:0] ncols,
  output logic       busy,
  output logic [7:0] sram_row,
  output logic [7:0] sram_col,
  output logic       sram_sense_en,
  output logic       sram_write_en,
  input  logic [7:0] sram_dout,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
`ifdef IO_TX_EOL_EN
  output logic       dout_eol,
`endif
  output logic       dout_last
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef IO_TX_EOL_EN
  localparam int unsigned TagW = 3;  // {valid, last, eol}
`else
  localparam int unsigned TagW = 2;  // {valid, last}
`endif
  localparam int unsigned EntW = 8 + TagW - 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q, state_d;
  logic [8:0]          nrows_q, nrows_d, ncols_q, ncols_d;
  logic [8:0]          row_q, row_d, col_q, col_d;
  logic [TagW-1:0]     tag_q [RD_LAT];
  logic [TagW-1:0]     tag_d [RD_LAT];
  logic [TagW-1:0]     tag_new;
  logic [EntW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d, inflight_q, inflight_d;

  logic                issue, load, is_last, credit_ok;
  logic                in_valid, fifo_empty, push, pop, accept, head_last;
  logic [TagW-1:0]     arrive;
  logic [EntW-1:0]     in_payload, head;

  assign is_last   = (row_q == nrows_q) && (col_q == ncols_q);
  assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CntW + 1)'(FIFO_DEPTH);

`ifdef IO_TX_EOL_EN
  logic is_eol;
  assign is_eol  = (col_q == ncols_q);
  assign tag_new = {issue, issue & is_last, issue & is_eol};
`else
  assign tag_new = {issue, issue & is_last};
`endif

  // Tag pipe delays {valid, flags} by RD_LAT so each tag lines up with its returning data.
  always_comb begin
    tag_d[0] = tag_new;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign arrive     = tag_q[RD_LAT-1];
  assign in_valid   = arrive[TagW-1];
  assign in_payload = {sram_dout, arrive[TagW-2:0]};

  // An empty FIFO passes returning data straight to the output; it is only stored if not taken.
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_empty ? in_payload : mem_q[rd_ptr_q];
  assign dout_valid = !fifo_empty || in_valid;
  assign accept     = dout_valid && dout_ready;
  assign push       = in_valid && !(fifo_empty && dout_ready);
  assign pop        = !fifo_empty && dout_ready;
  assign head_last  = head[TagW-2];

  assign count_d    = count_q + CntW'(push) - CntW'(pop);
  assign inflight_d = inflight_q + CntW'(issue) - CntW'(in_valid);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (is_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (accept && head_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    nrows_d = nrows_q;
    ncols_d = ncols_q;
    row_d   = row_q;
    col_d   = col_q;
    if (load) begin
      nrows_d = {1'b0, nrows};
      ncols_d = {1'b0, ncols};
      row_d   = '0;
      col_d   = '0;
    end else if (issue) begin
      if (col_q == ncols_q) begin
        col_d = '0;
        row_d = row_q + 9'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      nrows_q    <= '0;
      ncols_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= tag_d[i];
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_payload;
  end

  // Credit accounting guarantees returning data always finds room.
  push_never_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (count_q == CntW'(FIFO_DEPTH))));

  assign busy          = (state_q != StIdle);
  assign sram_row      = row_q[7:0];
  assign sram_col      = col_q[7:0];
  assign sram_sense_en = issue;
  assign sram_write_en = 1'b0;
  assign dout          = dout_valid ? head[EntW-1:TagW-1] : 8'h00;
  assign dout_last     = dout_valid & head_last;
`ifdef IO_TX_EOL_EN
  assign dout_eol      = dout_valid & head[0];
`endif

endmodule

// File: doc/io_tx_controller.md
Name: io_tx_controller

Overview:
- Streams a stored image out of image SRAM in raster order (row 0 col 0 first) as a byte stream with a valid/ready handshake.
- It is the readback counterpart of the RX write path. It consumes what the RX controller and the convolution engine leave in image SRAM.
- Pipelined SRAM reads feed a small output FIFO, so back-pressure on the output never loses or duplicates a pixel.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles: row/col presented with sense_en=1 at cycle t gives sram_dout valid at cycle t+RD_LAT.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1; power of two.

Ports:
- clk  input  1  single clock; same clock as img_sram_intf.clk.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  start pulse; sampled only in IDLE.
- nrows  input  8  last row index (inclusive); sampled on accepted start.
- ncols  input  8  last col index (inclusive); sampled on accepted start.
- busy  output  1  high from accepted start until the last byte is accepted.
- sram_row  output  8  SRAM row address.
- sram_col  output  8  SRAM col address.
- sram_sense_en  output  1  read strobe; high only on cycles that issue a read.
- sram_write_en  output  1  tied 0.
- sram_dout  input  8  SRAM read data.
- dout  output  8  pixel byte.
- dout_valid  output  1  dout holds a valid pixel.
- dout_ready  input  1  downstream accepts when valid && ready.
- dout_last  output  1  high with the final pixel (row nrows, col ncols).

Behaviour:
- Reset (async, rstn=0): state IDLE; busy=0; dout_valid=0; dout_last=0; dout=0; sram_sense_en=0; sram_row=0; sram_col=0; FIFO empty; in-flight count 0. Reset mid-frame aborts immediately; partial data is discarded.
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on start=1. Latch nrows/ncols into 9-bit limit registers. Clear the address counters. busy=1 from the next cycle.
- ISSUE:
  - Issue a read (sense_en=1, row/col = counters) in any cycle where credit > 0.
  - credit = FIFO_DEPTH - fifo_count - inflight, where inflight = number of issued reads whose data has not yet returned.
  - Counter advance: col+1; at col==ncols, col=0 and row+1.
  - The read of (nrows, ncols) is tagged last. ISSUE -> DRAIN after that read is issued.
- Read-data capture: a RD_LAT-deep shift register of {valid, last} tags pairs each read with its returning data. When the tag arrives, sram_dout and the tag are pushed into the FIFO. A push can never find the FIFO full; assert this in simulation.
- Output: dout, dout_valid and dout_last come from the FIFO head (show-ahead). Pop on dout_valid && dout_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop from an empty FIFO is impossible (valid=0).
- DRAIN -> IDLE in the cycle the last-tagged byte is popped. busy falls the next cycle.
- Throughput: with dout_ready held 1, one byte per cycle sustained after the initial latency.
- First dout_valid appears 1+RD_LAT cycles after the start cycle.
- Total bytes per frame = (nrows+1)*(ncols+1).
  - nrows=ncols=0 gives 1 byte.
  - nrows=ncols=255 gives 65536 bytes.
  - Counters are 9 bits so the 255 limit does not wrap early.
- start while busy is ignored.
- dout_ready may toggle arbitrarily. While valid && !ready, dout and dout_last must hold stable.

Optional Feature:
- Macro IO_TX_EOL_EN.
- Defined: adds output dout_eol (1 bit). It is high with every pixel at col==ncols (end of row); it is carried through the tag pipe and FIFO like last. The final pixel has both eol and last set. dout_eol resets to 0.
- Undefined: no dout_eol port; tag width is 2 bits (valid, last).

Test Plan:
- Reset, then start with nrows=1, ncols=2, SRAM preloaded with value = row*16+col, ready=1. Expect dout sequence 00,01,02,10,11,12 on consecutive cycles; last only on 12; busy drops 1 cycle after that pop.
- nrows=0, ncols=0, SRAM[0][0]=A5. Expect exactly one byte A5 with dout_last=1, then IDLE.
- 4x4 frame with dout_ready random 50%. Expect all 16 bytes in order, none duplicated or dropped; dout stable while stalled; sense_en never issued with credit=0.
- dout_ready=0 for 20 cycles after start. Expect exactly FIFO_DEPTH reads issued, then sense_en=0 until ready rises; full order preserved.
- Assert rstn=0 mid-frame at byte 5 of a 3x3 frame. Expect dout_valid=0 and busy=0 immediately. A subsequent start streams the full frame from (0,0).
- With IO_TX_EOL_EN and nrows=2, ncols=3: dout_eol high on bytes 4, 8 and 12 (1-based); last only on byte 12.
